// File: rtl/edac_encode_4bit.sv
// rtl/edac_encode_4bit.sv - nibble-serial CRC-8 encoder emitting {data, crc} codewords
// Optional fault injection on the emitted codeword: define EDAC_ENC_ERRINJ_EN.
module edac_encode_4bit #(
    parameter int DATA_W       = 16,
    parameter int CRC_W        = 8,
    parameter int BITS_PER_CYC = 4
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       DIN,
    input  logic [CRC_W-1:0]        CRC_POLY,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       DOUT,
    output logic [CRC_W-1:0]        CRC_OUT,
`ifdef EDAC_ENC_ERRINJ_EN
    input  logic [DATA_W+CRC_W-1:0] inj_mask,
`endif
    output logic                    busy
);

    localparam int NIB   = DATA_W / BITS_PER_CYC;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB - 1);

    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [CRC_W-1:0]    crc_q;
    logic [CRC_W-1:0]    crc_next;
    logic [CRC_W-1:0]    poly_q;
    logic [DATA_W-1:0]   shift_q;
    logic [DATA_W-1:0]   inj_data;
    logic [CRC_W-1:0]    inj_crc;

    // MSB-first fold of one chunk; the oldest data bit is the chunk's MSB.
    function automatic logic [CRC_W-1:0] fold(input logic [CRC_W-1:0]        crc,
                                              input logic [BITS_PER_CYC-1:0] bits,
                                              input logic [CRC_W-1:0]        poly);
        logic [CRC_W-1:0] c;
        logic             fb;
        c = crc;
        for (int i = BITS_PER_CYC - 1; i >= 0; i--) begin
            fb = c[CRC_W-1] ^ bits[i];
            c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? poly : '0);
        end
        return c;
    endfunction

    always_comb begin
        crc_next = fold(crc_q, shift_q[DATA_W-1 -: BITS_PER_CYC], poly_q);
    end

`ifdef EDAC_ENC_ERRINJ_EN
    logic [DATA_W+CRC_W-1:0] mask_q;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            mask_q <= '0;
        end else if (en && state == IDLE && in_valid) begin
            mask_q <= inj_mask;
        end
    end

    assign inj_data = mask_q[DATA_W+CRC_W-1:CRC_W];
    assign inj_crc  = mask_q[CRC_W-1:0];
`else
    assign inj_data = '0;
    assign inj_crc  = '0;
`endif

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            DOUT      <= '0;
            CRC_OUT   <= '0;
            cnt       <= '0;
            crc_q     <= '0;
            poly_q    <= '0;
            shift_q   <= '0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shift_q  <= DIN;
                        DOUT     <= DIN;
                        poly_q   <= CRC_POLY;
                        crc_q    <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    crc_q   <= crc_next;
                    shift_q <= shift_q << BITS_PER_CYC;
                    if (cnt == CNT_LAST) begin
                        // Injection applies only to the presented codeword, never to the CRC math.
                        CRC_OUT   <= crc_next ^ inj_crc;
                        DOUT      <= DOUT ^ inj_data;
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edac_encode_4bit.sv
// tb/tb_edac_encode_4bit.sv - self-checking bench for edac_encode_4bit
module tb_edac_encode_4bit;

    logic        CLK       = 1'b0;
    logic        reset     = 1'b1;
    logic        en        = 1'b1;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] DIN       = 16'h0000;
    logic [7:0]  CRC_POLY  = 8'h00;
    logic        in_ready;
    logic        out_valid;
    logic        busy;
    logic [15:0] DOUT;
    logic [7:0]  CRC_OUT;
`ifdef EDAC_ENC_ERRINJ_EN
    logic [23:0] inj_mask  = 24'h0;
`endif

    int n_cmp  = 0;
    int n_err  = 0;
    bit chk_on = 1'b0;

    edac_encode_4bit dut (
        .CLK       (CLK),
        .reset     (reset),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .DIN       (DIN),
        .CRC_POLY  (CRC_POLY),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .DOUT      (DOUT),
        .CRC_OUT   (CRC_OUT),
`ifdef EDAC_ENC_ERRINJ_EN
        .inj_mask  (inj_mask),
`endif
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    // CRC as the remainder of data * x^8 divided by x^8 + poly (GF(2) long division).
    function automatic logic [7:0] crc_ref(input logic [15:0] d, input logic [7:0] p);
        logic [23:0] v;
        logic [8:0]  g;
        v = {d, 8'h00};
        g = {1'b1, p};
        for (int i = 23; i >= 8; i--) begin
            if (v[i]) v = v ^ ({15'd0, g} << (i - 8));
        end
        return v[7:0];
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: a word is pending for 4 enabled edges, then held until out_ready.
    int          m_left  = 0;
    bit          m_valid = 1'b0;
    logic [15:0] m_dout  = 16'h0;
    logic [7:0]  m_crc   = 8'h0;
    logic [7:0]  m_pend  = 8'h0;
    logic [23:0] m_mask  = 24'h0;

    always @(posedge CLK or posedge reset) begin
        if (reset) begin
            m_left  = 0;
            m_valid = 1'b0;
            m_dout  = 16'h0;
            m_crc   = 8'h0;
        end else if (en) begin
            if (m_left == 0 && !m_valid) begin
                if (in_valid) begin
                    m_dout = DIN;
                    m_pend = crc_ref(DIN, CRC_POLY);
                    m_left = 4;
`ifdef EDAC_ENC_ERRINJ_EN
                    m_mask = inj_mask;
`else
                    m_mask = 24'h0;
`endif
                end
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_valid = 1'b1;
                    m_crc   = m_pend ^ m_mask[7:0];
                    m_dout  = m_dout ^ m_mask[23:8];
                end
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(posedge CLK) begin
        #1;
        if (chk_on) begin
            check("mdl_in_ready",  in_ready,  (m_left == 0 && !m_valid));
            check("mdl_busy",      busy,      !(m_left == 0 && !m_valid));
            check("mdl_out_valid", out_valid, m_valid);
            check("mdl_dout",      DOUT,      m_dout);
            check("mdl_crc_out",   CRC_OUT,   m_crc);
        end
    end

    task automatic send(input logic [15:0] d, input logic [7:0] p);
        @(negedge CLK);
        check("send_in_ready", in_ready, 1'b1);
        DIN      = d;
        CRC_POLY = p;
        in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        DIN      = ~d;
        CRC_POLY = ~p;
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        repeat (50) begin
            @(posedge CLK);
            #1;
            edges++;
            if (out_valid) break;
        end
        if (!out_valid) check("valid_timeout", out_valid, 1'b1);
    endtask

    task automatic run(input logic [15:0] d, input logic [7:0] p,
                       input logic [7:0] exp_crc, input logic [15:0] exp_dout);
        int edges;
        send(d, p);
        wait_valid(edges);
        check("latency",  edges,   4);
        check("crc_lit",  CRC_OUT, exp_crc);
        check("dout_lit", DOUT,    exp_dout);
        @(posedge CLK);
        #1;
        check("valid_one_cycle", out_valid, 1'b0);
    endtask

    initial begin
        int edges;
        repeat (3) @(negedge CLK);
        check("rst_in_ready",  in_ready,  1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy",      busy,      1'b0);
        check("rst_dout",      DOUT,      16'h0);
        check("rst_crc",       CRC_OUT,   8'h0);
        reset  = 1'b0;
        chk_on = 1'b1;

        run(16'h0001, 8'h07, 8'h07, 16'h0001);
        run(16'h0100, 8'h07, 8'h15, 16'h0100);
        run(16'h8000, 8'h07, 8'hB6, 16'h8000);
        run(16'h0000, 8'h07, 8'h00, 16'h0000);
        run(16'hBEEF, 8'h00, 8'h00, 16'hBEEF);

        // Back-pressure in HOLD with in_valid pushed throughout.
        out_ready = 1'b0;
        send(16'h8000, 8'h07);
        wait_valid(edges);
        check("hold_latency", edges, 4);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            in_valid = 1'b1;
            DIN      = 16'h1234;
            CRC_POLY = 8'h31;
            @(posedge CLK);
            #1;
            check("hold_valid", out_valid, 1'b1);
            check("hold_crc",   CRC_OUT,   8'hB6);
            check("hold_dout",  DOUT,      16'h8000);
            check("hold_ready", in_ready,  1'b0);
        end
        @(negedge CLK);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        check("hold_release_valid", out_valid, 1'b0);
        check("hold_release_ready", in_ready,  1'b1);

        // Enable stall after the second nibble.
        send(16'h0100, 8'h07);
        @(negedge CLK);
        @(negedge CLK);
        en = 1'b0;
        repeat (3) @(negedge CLK);
        en = 1'b1;
        check("stall_not_valid", out_valid, 1'b0);
        wait_valid(edges);
        check("stall_latency", edges,   2);
        check("stall_crc",     CRC_OUT, 8'h15);
        @(posedge CLK);
        #1;
        check("stall_drop", out_valid, 1'b0);

        // Reset during CALC aborts the word.
        send(16'h0001, 8'h07);
        @(negedge CLK);
        @(negedge CLK);
        reset = 1'b1;
        #1;
        check("abort_in_ready",  in_ready,  1'b1);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_busy",      busy,      1'b0);
        check("abort_dout",      DOUT,      16'h0);
        check("abort_crc",       CRC_OUT,   8'h0);
        @(negedge CLK);
        reset = 1'b0;
        run(16'h0001, 8'h07, 8'h07, 16'h0001);

`ifdef EDAC_ENC_ERRINJ_EN
        inj_mask = 24'h000001;
        run(16'h0001, 8'h07, 8'h06, 16'h0001);
        inj_mask = 24'h000100;
        run(16'h0001, 8'h07, 8'h07, 16'h0000);
        inj_mask = 24'h000000;
`endif

        repeat (3) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
